alu_op_sequencer: RTL and testbench

- Sits between the UART packet parser and the TX response serializer.
- Receives a decoded command header, then a stream of 32-bit little-endian operand words.
- Sequences the shared multi-cycle multiplier and divider and the in-block adder, then emits response words.
- Opcodes handled: ECHO 0xEC, ADD 0xA0, MUL 0xA1, DIV 0xA2.

---
 rtl/alu_op_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Purpose: command sequencer between the packet parser and the response serializer; runs ECHO/ADD/MUL/DIV over operand words.
// Latency: ECHO is a zero-cycle pass-through; ADD takes one cycle per word; MUL/DIV wait on the external units; the response follows in RSP0/RSP1.
// Backpressure: cmd_ready_o is high only in IDLE; opnd_ready_o follows rsp_ready_i in ECHO and drops while the multiplier/divider is busy; rsp_* hold until accepted.
//
// Ports: clk_i/rst_i (synchronous, active-high); cmd_* header handshake (opcode, word count);
//        opnd_* operand stream; mul_*/div_* start/done interface to the shared units;
//        rsp_* response word stream with last marker; err_o bad-command pulse; ovf_o sticky overflow.
// Optional: define ALU_SEQ_OVF_EN to build the overflow flag; otherwise ovf_o is tied to 0.
module alu_op_sequencer #(
  parameter int         WORDS_W = 14,
  parameter logic [7:0] ECHO_OP = 8'hEC,
  parameter logic [7:0] ADD_OP  = 8'hA0,
  parameter logic [7:0] MUL_OP  = 8'hA1,
  parameter logic [7:0] DIV_OP  = 8'hA2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [7:0]         cmd_opcode_i,
  input  logic [WORDS_W-1:0] cmd_words_i,
  input  logic               opnd_valid_i,
  output logic               opnd_ready_o,
  input  logic [31:0]        opnd_data_i,
  output logic               mul_start_o,
  output logic [31:0]        mul_a_o,
  output logic [31:0]        mul_b_o,
  input  logic               mul_done_i,
  input  logic [63:0]        mul_result_i,
  output logic               div_start_o,
  output logic [31:0]        div_a_o,
  output logic [31:0]        div_b_o,
  input  logic               div_done_i,
  input  logic [31:0]        div_quot_i,
  input  logic [31:0]        div_rem_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [31:0]        rsp_data_o,
  output logic               rsp_last_o,
  output logic               err_o,
  output logic               ovf_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ECHO,
    S_ACC,
    S_MUL_WAIT,
    S_DIV_B,
    S_DIV_WAIT,
    S_RSP0,
    S_RSP1,
    S_DRAIN
  } state_t;

  localparam logic [WORDS_W-1:0] CNT_ZERO = '0;
  localparam logic [WORDS_W-1:0] CNT_ONE  = WORDS_W'(1);
  localparam logic [WORDS_W-1:0] CNT_TWO  = WORDS_W'(2);

  state_t             state_q, state_d;
  logic [7:0]         op_q, op_d;
  logic [WORDS_W-1:0] cnt_q, cnt_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        quot_q, quot_d;
  logic [31:0]        rem_q, rem_d;
  logic [31:0]        mul_a_q, mul_a_d;
  logic [31:0]        mul_b_q, mul_b_d;
  logic [31:0]        div_a_q, div_a_d;
  logic [31:0]        div_b_q, div_b_d;
  logic               mul_start_q, mul_start_d;
  logic               div_start_q, div_start_d;
  logic               err_q, err_d;

  logic [32:0]        add_sum;
  logic               cnt_is_zero;
  logic               cnt_is_one;

  assign add_sum     = {1'b0, acc_q} + {1'b0, opnd_data_i};
  assign cnt_is_zero = (cnt_q == CNT_ZERO);
  assign cnt_is_one  = (cnt_q == CNT_ONE);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    mul_start_d  = 1'b0;
    div_start_d  = 1'b0;
    err_d        = 1'b0;
    cmd_ready_o  = 1'b0;
    opnd_ready_o = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_data_o   = '0;
    rsp_last_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          op_d  = cmd_opcode_i;
          cnt_d = cmd_words_i;
          case (cmd_opcode_i)
            ECHO_OP: state_d = S_ECHO;
            ADD_OP: begin
              acc_d   = 32'd0;
              state_d = (cmd_words_i == CNT_ZERO) ? S_RSP0 : S_ACC;
            end
            MUL_OP: begin
              // Multiplicative identity so an empty MUL answers 1.
              acc_d   = 32'd1;
              state_d = (cmd_words_i == CNT_ZERO) ? S_RSP0 : S_ACC;
            end
            DIV_OP: begin
              if (cmd_words_i == CNT_TWO) begin
                state_d = S_ACC;
              end else begin
                state_d = S_DRAIN;
                err_d   = 1'b1;
              end
            end
            default: begin
              state_d = S_DRAIN;
              err_d   = 1'b1;
            end
          endcase
        end
      end

      S_ECHO: begin
        if (cnt_is_zero) begin
          state_d = S_IDLE;
        end else begin
          // Straight wire from operand stream to response stream.
          opnd_ready_o = rsp_ready_i;
          rsp_valid_o  = opnd_valid_i;
          rsp_data_o   = opnd_data_i;
          rsp_last_o   = cnt_is_one;
          if (opnd_valid_i && rsp_ready_i) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_is_one) state_d = S_IDLE;
          end
        end
      end

      S_ACC: begin
        opnd_ready_o = 1'b1;
        if (opnd_valid_i) begin
          cnt_d = cnt_q - CNT_ONE;
          if (op_q == DIV_OP) begin
            // First DIV word is the dividend.
            acc_d   = opnd_data_i;
            state_d = S_DIV_B;
          end else if (op_q == MUL_OP) begin
            mul_a_d     = acc_q;
            mul_b_d     = opnd_data_i;
            mul_start_d = 1'b1;
            state_d     = S_MUL_WAIT;
          end else begin
            acc_d = add_sum[31:0];
            if (cnt_is_one) state_d = S_RSP0;
          end
        end
      end

      S_MUL_WAIT: begin
        if (mul_done_i) begin
          acc_d   = mul_result_i[31:0];
          state_d = cnt_is_zero ? S_RSP0 : S_ACC;
        end
      end

      S_DIV_B: begin
        opnd_ready_o = 1'b1;
        if (opnd_valid_i) begin
          cnt_d = cnt_q - CNT_ONE;
          if (opnd_data_i == 32'd0) begin
            // Divide by zero is answered locally; the divider never sees it.
            quot_d  = 32'hFFFF_FFFF;
            rem_d   = acc_q;
            state_d = S_RSP0;
          end else begin
            div_a_d     = acc_q;
            div_b_d     = opnd_data_i;
            div_start_d = 1'b1;
            state_d     = S_DIV_WAIT;
          end
        end
      end

      S_DIV_WAIT: begin
        if (div_done_i) begin
          quot_d  = div_quot_i;
          rem_d   = div_rem_i;
          state_d = S_RSP0;
        end
      end

      S_RSP0: begin
        rsp_valid_o = 1'b1;
        if (op_q == DIV_OP) begin
          rsp_data_o = rem_q;
          rsp_last_o = 1'b0;
        end else begin
          rsp_data_o = acc_q;
          rsp_last_o = 1'b1;
        end
        if (rsp_ready_i) state_d = (op_q == DIV_OP) ? S_RSP1 : S_IDLE;
      end

      S_RSP1: begin
        rsp_valid_o = 1'b1;
        rsp_data_o  = quot_q;
        rsp_last_o  = 1'b1;
        if (rsp_ready_i) state_d = S_IDLE;
      end

      S_DRAIN: begin
        if (cnt_is_zero) begin
          state_d = S_IDLE;
        end else begin
          opnd_ready_o = 1'b1;
          if (opnd_valid_i) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_is_one) state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      mul_start_q <= mul_start_d;
      div_start_q <= div_start_d;
      err_q       <= err_d;
    end
  end

  assign mul_start_o = mul_start_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign div_start_o = div_start_q;
  assign div_a_o     = div_a_q;
  assign div_b_o     = div_b_q;
  assign err_o       = err_q;

`ifdef ALU_SEQ_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky for the life of one command; a new header starts it clean.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_IDLE && cmd_valid_i) begin
      ovf_d = 1'b0;
    end else if (state_q == S_ACC && op_q == ADD_OP && opnd_valid_i && add_sum[32]) begin
      ovf_d = 1'b1;
    end else if (state_q == S_MUL_WAIT && mul_done_i && (mul_result_i[63:32] != 32'd0)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^{add_sum[32], mul_result_i[63:32]};
  assign ovf_o      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  localparam int WORDS_W = 14;

`ifdef ALU_SEQ_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [7:0]         cmd_opcode_i;
  logic [WORDS_W-1:0] cmd_words_i;
  logic               opnd_valid_i;
  logic               opnd_ready_o;
  logic [31:0]        opnd_data_i;
  logic               mul_start_o;
  logic [31:0]        mul_a_o, mul_b_o;
  logic               mul_done_i;
  logic [63:0]        mul_result_i;
  logic               div_start_o;
  logic [31:0]        div_a_o, div_b_o;
  logic               div_done_i;
  logic [31:0]        div_quot_i, div_rem_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [31:0]        rsp_data_o;
  logic               rsp_last_o;
  logic               err_o;
  logic               ovf_o;

  alu_op_sequencer #(.WORDS_W(WORDS_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_opcode_i(cmd_opcode_i), .cmd_words_i(cmd_words_i),
    .opnd_valid_i(opnd_valid_i), .opnd_ready_o(opnd_ready_o), .opnd_data_i(opnd_data_i),
    .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_done_i(mul_done_i), .mul_result_i(mul_result_i),
    .div_start_o(div_start_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_done_i(div_done_i), .div_quot_i(div_quot_i), .div_rem_i(div_rem_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_last_o(rsp_last_o),
    .err_o(err_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: expected responses plus counts of side effects.
  logic [31:0] exp_dat_q[$];
  bit          exp_last_q[$];
  logic [31:0] got_q[$];
  logic [31:0] wbuf[16];
  int          exp_mul = 0, exp_div = 0, exp_err = 0;
  bit          exp_ovf = 1'b0;
  int          mul_starts = 0, div_starts = 0, err_seen = 0;
  bit          mul_abort = 1'b0;
  bit          lat_rand = 1'b0;
  bit          fast = 1'b0;
  int          rsp_mode = 0;
  int          opnd_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [63:0] got_at(input int i);
    if (i < got_q.size()) return {32'd0, got_q[i]};
    return 64'h1_0000_0000;
  endfunction

  // What one command must produce, from the opcode rules alone.
  task automatic model_cmd(input logic [7:0] op, input int n);
    logic [31:0] a;
    logic [63:0] t;
    exp_ovf = 1'b0;
    if (op == 8'hEC) begin
      for (int i = 0; i < n; i++) begin
        exp_dat_q.push_back(wbuf[i]);
        exp_last_q.push_back(i == n - 1);
      end
    end else if (op == 8'hA0) begin
      a = 32'd0;
      for (int i = 0; i < n; i++) begin
        t = {32'd0, a} + {32'd0, wbuf[i]};
        if (t[32]) exp_ovf = 1'b1;
        a = t[31:0];
      end
      exp_dat_q.push_back(a);
      exp_last_q.push_back(1'b1);
    end else if (op == 8'hA1) begin
      a = 32'd1;
      for (int i = 0; i < n; i++) begin
        t = {32'd0, a} * {32'd0, wbuf[i]};
        if (t[63:32] != 32'd0) exp_ovf = 1'b1;
        a = t[31:0];
        exp_mul++;
      end
      exp_dat_q.push_back(a);
      exp_last_q.push_back(1'b1);
    end else if (op == 8'hA2 && n == 2) begin
      if (wbuf[1] == 32'd0) begin
        exp_dat_q.push_back(wbuf[0]);
        exp_last_q.push_back(1'b0);
        exp_dat_q.push_back(32'hFFFF_FFFF);
        exp_last_q.push_back(1'b1);
      end else begin
        exp_dat_q.push_back(wbuf[0] % wbuf[1]);
        exp_last_q.push_back(1'b0);
        exp_dat_q.push_back(wbuf[0] / wbuf[1]);
        exp_last_q.push_back(1'b1);
        exp_div++;
      end
    end else begin
      exp_err++;
    end
  endtask

  task automatic send_cmd(input logic [7:0] op, input int n);
    int guard;
    bit fire;
    bit echo;
    echo = (op == 8'hEC);
    @(posedge clk_i); #1;
    cmd_valid_i  = 1'b1;
    cmd_opcode_i = op;
    cmd_words_i  = n[WORDS_W-1:0];
    guard = 0;
    fire  = 1'b0;
    while (!fire && guard < 3000) begin
      @(negedge clk_i);
      fire = cmd_ready_o;
      @(posedge clk_i); #1;
      guard++;
    end
    cmd_valid_i = 1'b0;
    if (!fire) timeout("hdr_accept");
    opnd_cycles = 0;
    for (int i = 0; i < n; i++) begin
      fire  = 1'b0;
      guard = 0;
      opnd_data_i = wbuf[i];
      while (!fire && guard < 3000) begin
        if (!opnd_valid_i) opnd_valid_i = fast || ($urandom_range(0, 3) != 0);
        @(negedge clk_i);
        if (echo) begin
          check("echo_vld", rsp_valid_o, opnd_valid_i);
          check("echo_rdy", opnd_ready_o, rsp_ready_i);
          if (opnd_valid_i) check("echo_dat", rsp_data_o, opnd_data_i);
        end
        fire = opnd_valid_i && opnd_ready_o;
        @(posedge clk_i); #1;
        guard++;
        opnd_cycles++;
      end
      opnd_valid_i = 1'b0;
      if (!fire) timeout("opnd_accept");
    end
  endtask

  task automatic run_cmd(input logic [7:0] op, input int n);
    model_cmd(op, n);
    send_cmd(op, n);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk_i);
      g++;
    end while (!(cmd_ready_o && exp_dat_q.size() == 0) && g < 5000);
    if (g >= 5000) timeout("idle");
  endtask

  // Response sink.
  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      case (rsp_mode)
        0:       rsp_ready_i = 1'b1;
        1:       rsp_ready_i = ($urandom_range(0, 2) != 0);
        default: rsp_ready_i = 1'b0;
      endcase
    end
  end

  // Response monitor / scoreboard.
  initial begin
    bit          pv, pa;
    logic [31:0] pd;
    logic [31:0] e;
    bit          el;
    pv = 1'b0;
    pa = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        pv = 1'b0;
        continue;
      end
      if (err_o) err_seen++;
      if (pv && !pa) begin
        check("rsp_hold_vld", rsp_valid_o, 1);
        check("rsp_hold_dat", rsp_data_o, pd);
      end
      if (rsp_valid_o) check("rsp_expected", exp_dat_q.size() != 0, 1);
      if (rsp_valid_o && rsp_ready_i) begin
        got_q.push_back(rsp_data_o);
        if (exp_dat_q.size() != 0) begin
          e  = exp_dat_q.pop_front();
          el = exp_last_q.pop_front();
          check("rsp_dat", rsp_data_o, e);
          check("rsp_last", rsp_last_o, el);
        end
      end
      pv = rsp_valid_o;
      pa = rsp_ready_i;
      pd = rsp_data_o;
    end
  end

  // Multiplier unit: fixed 10-cycle or random latency.
  initial begin
    logic [31:0] ma, mb;
    int lat;
    mul_done_i   = 1'b0;
    mul_result_i = '0;
    forever begin
      @(negedge clk_i);
      if (mul_start_o) begin
        ma = mul_a_o;
        mb = mul_b_o;
        mul_starts++;
        lat = lat_rand ? $urandom_range(1, 12) : 10;
        repeat (lat) begin
          @(negedge clk_i);
          if (!mul_abort) begin
            check("mul_a_hold", mul_a_o, ma);
            check("mul_b_hold", mul_b_o, mb);
            check("mul_start_pulse", mul_start_o, 0);
          end
        end
        @(posedge clk_i); #1;
        mul_done_i   = 1'b1;
        mul_result_i = {32'd0, ma} * {32'd0, mb};
        @(posedge clk_i); #1;
        mul_done_i   = 1'b0;
      end
    end
  end

  // Divider unit.
  initial begin
    logic [31:0] da, db;
    int lat;
    div_done_i = 1'b0;
    div_quot_i = '0;
    div_rem_i  = '0;
    forever begin
      @(negedge clk_i);
      if (div_start_o) begin
        da = div_a_o;
        db = div_b_o;
        div_starts++;
        lat = lat_rand ? $urandom_range(1, 12) : 8;
        repeat (lat) begin
          @(negedge clk_i);
          check("div_a_hold", div_a_o, da);
          check("div_b_hold", div_b_o, db);
          check("div_start_pulse", div_start_o, 0);
        end
        @(posedge clk_i); #1;
        div_done_i = 1'b1;
        div_quot_i = (db == 32'd0) ? 32'hFFFF_FFFF : da / db;
        div_rem_i  = (db == 32'd0) ? da : da % db;
        @(posedge clk_i); #1;
        div_done_i = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_rdy"},   cmd_ready_o, 1);
    check({tag, "_opnd_rdy"},  opnd_ready_o, 0);
    check({tag, "_mul_start"}, mul_start_o, 0);
    check({tag, "_mul_a"},     mul_a_o, 0);
    check({tag, "_mul_b"},     mul_b_o, 0);
    check({tag, "_div_start"}, div_start_o, 0);
    check({tag, "_div_a"},     div_a_o, 0);
    check({tag, "_div_b"},     div_b_o, 0);
    check({tag, "_rsp_vld"},   rsp_valid_o, 0);
    check({tag, "_rsp_dat"},   rsp_data_o, 0);
    check({tag, "_rsp_last"},  rsp_last_o, 0);
    check({tag, "_err"},       err_o, 0);
    check({tag, "_ovf"},       ovf_o, 0);
  endtask

  initial begin
    int s0, e0, g;
    logic [7:0] op;
    int n;
    rst_i        = 1'b1;
    cmd_valid_i  = 1'b0;
    cmd_opcode_i = '0;
    cmd_words_i  = '0;
    opnd_valid_i = 1'b0;
    opnd_data_i  = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_idle_outputs("reset");

    // ECHO: zero-latency pass-through.
    rsp_mode = 0; fast = 1'b1;
    wbuf[0] = 32'h11223344; wbuf[1] = 32'h55667788; wbuf[2] = 32'hA5A5A5A5; wbuf[3] = 32'h01020304;
    got_q.delete();
    run_cmd(8'hEC, 4);
    check("echo_cycles", opnd_cycles, 4);
    wait_idle();
    check("echo_w0", got_at(0), 64'h11223344);
    check("echo_w1", got_at(1), 64'h55667788);
    check("echo_w2", got_at(2), 64'hA5A5A5A5);
    check("echo_w3", got_at(3), 64'h01020304);

    // ADD with a carry out of bit 31.
    rsp_mode = 1; fast = 1'b0;
    wbuf[0] = 32'hFFFFFFFF; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
    got_q.delete();
    run_cmd(8'hA0, 4);
    wait_idle();
    check("add_result", got_at(0), 64'h8);
    check("add_ovf", ovf_o, OVF_EN ? 1 : 0);

    // MUL with a 10-cycle multiplier.
    wbuf[0] = 32'd3; wbuf[1] = 32'd5; wbuf[2] = 32'd7; wbuf[3] = 32'd1;
    got_q.delete();
    s0 = mul_starts;
    run_cmd(8'hA1, 4);
    wait_idle();
    check("mul_result", got_at(0), 64'h69);
    check("mul_starts", mul_starts - s0, 4);
    check("mul_ovf", ovf_o, OVF_EN ? exp_ovf : 0);

    // DIV 100 / 7, then divide by zero.
    wbuf[0] = 32'd100; wbuf[1] = 32'd7;
    got_q.delete();
    s0 = div_starts;
    run_cmd(8'hA2, 2);
    wait_idle();
    check("div_rem", got_at(0), 64'h2);
    check("div_quot", got_at(1), 64'hE);
    check("div_starts", div_starts - s0, 1);
    wbuf[1] = 32'd0;
    got_q.delete();
    s0 = div_starts;
    run_cmd(8'hA2, 2);
    wait_idle();
    check("div0_rem", got_at(0), 64'h64);
    check("div0_quot", got_at(1), 64'hFFFFFFFF);
    check("div0_no_start", div_starts - s0, 0);

    // Bad commands: error pulse, words drained, silent.
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
    got_q.delete();
    e0 = err_seen;
    run_cmd(8'h55, 3);
    wait_idle();
    check("bad_op_err", err_seen - e0, 1);
    check("bad_op_silent", got_q.size(), 0);
    e0 = err_seen;
    run_cmd(8'hA2, 3);
    wait_idle();
    check("div3_err", err_seen - e0, 1);
    check("div3_silent", got_q.size(), 0);

    // Response stall for 20 cycles.
    rsp_mode = 2;
    wbuf[0] = 32'd1; wbuf[1] = 32'd2;
    run_cmd(8'hA0, 2);
    g = 0;
    do begin @(negedge clk_i); g++; end while (!rsp_valid_o && g < 200);
    if (g >= 200) timeout("stall_rsp_vld");
    repeat (20) begin
      @(negedge clk_i);
      check("stall_cmd_rdy", cmd_ready_o, 0);
      check("stall_vld", rsp_valid_o, 1);
      check("stall_dat", rsp_data_o, 64'h3);
    end
    rsp_mode = 0;
    wait_idle();

    // Reset while the multiplier is busy; its late done must be ignored.
    lat_rand = 1'b0;
    wbuf[0] = 32'd9;
    send_cmd(8'hA1, 1);
    exp_mul++;
    mul_abort = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_idle_outputs("midrst");
    repeat (15) begin
      @(negedge clk_i);
      check("midrst_cmd_rdy", cmd_ready_o, 1);
      check("midrst_rsp_vld", rsp_valid_o, 0);
    end
    mul_abort = 1'b0;
    wbuf[0] = 32'd5; wbuf[1] = 32'd6;
    got_q.delete();
    run_cmd(8'hA0, 2);
    wait_idle();
    check("post_rst_add", got_at(0), 64'hB);

    // Random back-to-back commands.
    rsp_mode = 1; lat_rand = 1'b1;
    for (int c = 0; c < 40; c++) begin
      case ($urandom_range(0, 4))
        0: op = 8'hEC;
        1: op = 8'hA0;
        2: op = 8'hA1;
        3: op = 8'hA2;
        default: op = 8'($urandom_range(0, 8'h9F));
      endcase
      n = $urandom_range(0, 6);
      if (op == 8'hA2 && $urandom_range(0, 3) != 0) n = 2;
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      if (op == 8'hA1) for (int i = 0; i < 16; i++) wbuf[i] = $urandom_range(0, 300);
      if (op == 8'hA2 && $urandom_range(0, 3) == 0) wbuf[1] = 32'd0;
      run_cmd(op, n);
    end
    wait_idle();
    repeat (20) @(negedge clk_i);
    check("final_queue_empty", exp_dat_q.size(), 0);
    check("final_mul_starts", mul_starts, exp_mul);
    check("final_div_starts", div_starts, exp_div);
    check("final_err_count", err_seen, exp_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
